// File: rtl/niu_sii_req_tracker_if.sv
// NIU->SII request bus: header/payload strobes, data with lane parity, and the
// SII ordered-queue dequeue strobe returned toward the NIU.
interface niu_sii_req_tracker_if #(
    parameter int DATA_W = 128
);
    logic                   niu_sii_hdr_vld;
    logic                   niu_sii_reqbypass;
    logic                   niu_sii_datareq;
    logic                   niu_sii_datareq16;
    logic [DATA_W-1:0]      niu_sii_data;
    logic [DATA_W/16-1:0]   niu_sii_parity;
    logic                   sii_niu_oqdq;

    modport master (
        output niu_sii_hdr_vld,
        output niu_sii_reqbypass,
        output niu_sii_datareq,
        output niu_sii_datareq16,
        output niu_sii_data,
        output niu_sii_parity,
        output sii_niu_oqdq
    );

    modport slave (
        input niu_sii_hdr_vld,
        input niu_sii_reqbypass,
        input niu_sii_datareq,
        input niu_sii_datareq16,
        input niu_sii_data,
        input niu_sii_parity,
        input sii_niu_oqdq
    );
endinterface

// File: rtl/niu_sii_req_tracker.sv
// Tracks NIU->SII request headers and payload beats: per-type counters, last
// header fields, ordered-queue occupancy and sticky protocol/parity errors.
module niu_sii_req_tracker #(
    parameter int DATA_W        = 128,
    parameter int PAYLOAD_BEATS = 4,
    parameter int CNT_W         = 32,
    parameter int OQ_DEPTH      = 16
) (
    input  logic                           iol2clk,
    input  logic                           rst,
    input  logic                           enable,
    niu_sii_req_tracker_if.slave           bus,
    input  logic                           err_clr,
    output logic [CNT_W-1:0]               rd_cnt,
    output logic [CNT_W-1:0]               wr_cnt,
    output logic [CNT_W-1:0]               wr16_cnt,
    output logic [CNT_W-1:0]               byp_cnt,
    output logic [15:0]                    last_tag,
    output logic [39:0]                    last_pa,
    output logic                           hdr_evt,
    output logic                           beat_evt,
    output logic [$clog2(OQ_DEPTH+1)-1:0]  oq_level,
    output logic                           err_rwm,
    output logic                           err_hdr_in_pl,
    output logic                           err_parity,
    output logic                           err_oq_ovf,
    output logic                           err_oq_unf
);
    localparam int LANES  = DATA_W / 16;
    localparam int BEAT_W = $clog2(PAYLOAD_BEATS + 1);
    localparam int OQ_W   = $clog2(OQ_DEPTH + 1);

    localparam logic [BEAT_W-1:0] BEATS_FULL = BEAT_W'(PAYLOAD_BEATS);
    localparam logic [BEAT_W-1:0] BEATS_ONE  = BEAT_W'(1);
    localparam logic [BEAT_W-1:0] BEATS_NONE = BEAT_W'(0);
    localparam logic [OQ_W-1:0]   OQ_MAX     = OQ_W'(OQ_DEPTH);
    localparam logic [OQ_W-1:0]   OQ_ONE     = OQ_W'(1);
    localparam logic [OQ_W-1:0]   OQ_EMPTY   = OQ_W'(0);
    localparam logic [CNT_W-1:0]  CNT_MAX    = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ZERO   = CNT_W'(0);

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_PAYLOAD = 1'b1
    } state_t;

    function automatic logic [LANES-1:0] lane_parity(input logic [DATA_W-1:0] d);
        logic [LANES-1:0] p;
        for (int i = 0; i < LANES; i++) begin
            p[i] = ^d[16*i +: 16];
        end
        return p;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        if (c == CNT_MAX) begin
            return c;
        end else begin
            return c + CNT_ONE;
        end
    endfunction

    state_t              state_r, state_nxt_s;
    logic [BEAT_W-1:0]   rem_r, rem_nxt_s;
    logic [OQ_W-1:0]     oq_r, oq_nxt_s;
    logic [1:0]          rwm_s;
    logic                hdr_acc_s, beat_s, rwm_err_s, hdr_in_pl_s;
    logic                par_err_s, oq_inc_s, ovf_s, unf_s;

    logic [CNT_W-1:0]    rd_cnt_r, wr_cnt_r, wr16_cnt_r, byp_cnt_r;
    logic [15:0]         last_tag_r;
    logic [39:0]         last_pa_r;
    logic                hdr_evt_r, beat_evt_r;
    logic                err_rwm_r, err_hdr_in_pl_r, err_parity_r, err_oq_ovf_r, err_oq_unf_r;

    assign rwm_s     = {bus.niu_sii_datareq, bus.niu_sii_datareq16};
    assign par_err_s = (bus.niu_sii_hdr_vld || (state_r == ST_PAYLOAD)) &&
                       (bus.niu_sii_parity != lane_parity(bus.niu_sii_data));

    // Next-state and per-cycle event decode; a PAYLOAD cycle is always a beat.
    always_comb begin
        state_nxt_s = state_r;
        rem_nxt_s   = rem_r;
        hdr_acc_s   = 1'b0;
        beat_s      = 1'b0;
        rwm_err_s   = 1'b0;
        hdr_in_pl_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.niu_sii_hdr_vld) begin
                    case (rwm_s)
                        2'b00: begin
                            hdr_acc_s = 1'b1;
                        end
                        2'b10: begin
                            hdr_acc_s   = 1'b1;
                            state_nxt_s = ST_PAYLOAD;
                            rem_nxt_s   = BEATS_FULL;
                        end
                        2'b01: begin
                            hdr_acc_s   = 1'b1;
                            state_nxt_s = ST_PAYLOAD;
                            rem_nxt_s   = BEATS_ONE;
                        end
                        default: begin
                            rwm_err_s = 1'b1;
                        end
                    endcase
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_PAYLOAD: begin
                beat_s      = 1'b1;
                hdr_in_pl_s = bus.niu_sii_hdr_vld;
                if (rem_r <= BEATS_ONE) begin
                    state_nxt_s = ST_IDLE;
                    rem_nxt_s   = BEATS_NONE;
                end else begin
                    rem_nxt_s = rem_r - BEATS_ONE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                rem_nxt_s   = BEATS_NONE;
            end
        endcase
    end

    // Ordered-queue occupancy; a simultaneous push and pop cancel out.
    always_comb begin
        oq_nxt_s = oq_r;
        ovf_s    = 1'b0;
        unf_s    = 1'b0;
        oq_inc_s = hdr_acc_s && !bus.niu_sii_reqbypass;
        if (oq_inc_s && !bus.sii_niu_oqdq) begin
            if (oq_r == OQ_MAX) begin
                ovf_s = 1'b1;
            end else begin
                oq_nxt_s = oq_r + OQ_ONE;
            end
        end else if (!oq_inc_s && bus.sii_niu_oqdq) begin
            if (oq_r == OQ_EMPTY) begin
                unf_s = 1'b1;
            end else begin
                oq_nxt_s = oq_r - OQ_ONE;
            end
        end else begin
            oq_nxt_s = oq_r;
        end
    end

    // FSM state, beats remaining and queue level.
    always_ff @(posedge iol2clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            rem_r   <= BEATS_NONE;
            oq_r    <= OQ_EMPTY;
        end else if (enable) begin
            state_r <= state_nxt_s;
            rem_r   <= rem_nxt_s;
            oq_r    <= oq_nxt_s;
        end else begin
            state_r <= state_r;
            rem_r   <= rem_r;
            oq_r    <= oq_r;
        end
    end

    // Saturating header counters and last-header fields.
    always_ff @(posedge iol2clk) begin
        if (rst) begin
            rd_cnt_r   <= CNT_ZERO;
            wr_cnt_r   <= CNT_ZERO;
            wr16_cnt_r <= CNT_ZERO;
            byp_cnt_r  <= CNT_ZERO;
            last_tag_r <= 16'h0000;
            last_pa_r  <= 40'h00_0000_0000;
        end else if (enable && hdr_acc_s) begin
            last_tag_r <= bus.niu_sii_data[79:64];
            last_pa_r  <= bus.niu_sii_data[39:0];
            case (rwm_s)
                2'b00:   rd_cnt_r   <= sat_inc(rd_cnt_r);
                2'b10:   wr_cnt_r   <= sat_inc(wr_cnt_r);
                2'b01:   wr16_cnt_r <= sat_inc(wr16_cnt_r);
                default: rd_cnt_r   <= rd_cnt_r;
            endcase
            if (bus.niu_sii_reqbypass) begin
                byp_cnt_r <= sat_inc(byp_cnt_r);
            end else begin
                byp_cnt_r <= byp_cnt_r;
            end
        end else begin
            last_tag_r <= last_tag_r;
            last_pa_r  <= last_pa_r;
        end
    end

    // Event pulses and sticky errors; a fresh detection outranks err_clr.
    always_ff @(posedge iol2clk) begin
        if (rst) begin
            hdr_evt_r       <= 1'b0;
            beat_evt_r      <= 1'b0;
            err_rwm_r       <= 1'b0;
            err_hdr_in_pl_r <= 1'b0;
            err_parity_r    <= 1'b0;
            err_oq_ovf_r    <= 1'b0;
            err_oq_unf_r    <= 1'b0;
        end else if (enable) begin
            hdr_evt_r       <= hdr_acc_s;
            beat_evt_r      <= beat_s;
            err_rwm_r       <= (err_rwm_r       && !err_clr) || rwm_err_s;
            err_hdr_in_pl_r <= (err_hdr_in_pl_r && !err_clr) || hdr_in_pl_s;
            err_parity_r    <= (err_parity_r    && !err_clr) || par_err_s;
            err_oq_ovf_r    <= (err_oq_ovf_r    && !err_clr) || ovf_s;
            err_oq_unf_r    <= (err_oq_unf_r    && !err_clr) || unf_s;
        end else begin
            hdr_evt_r  <= 1'b0;
            beat_evt_r <= 1'b0;
        end
    end

    assign rd_cnt        = rd_cnt_r;
    assign wr_cnt        = wr_cnt_r;
    assign wr16_cnt      = wr16_cnt_r;
    assign byp_cnt       = byp_cnt_r;
    assign last_tag      = last_tag_r;
    assign last_pa       = last_pa_r;
    assign hdr_evt       = hdr_evt_r;
    assign beat_evt      = beat_evt_r;
    assign oq_level      = oq_r;
    assign err_rwm       = err_rwm_r;
    assign err_hdr_in_pl = err_hdr_in_pl_r;
    assign err_parity    = err_parity_r;
    assign err_oq_ovf    = err_oq_ovf_r;
    assign err_oq_unf    = err_oq_unf_r;
endmodule

// File: tb/tb_niu_sii_req_tracker.sv
// Directed plus randomized bench for niu_sii_req_tracker, checked every cycle
// against a behavioural model of the request/payload/queue rules.
module tb_niu_sii_req_tracker;
    localparam int DATA_W        = 128;
    localparam int PAYLOAD_BEATS = 4;
    localparam int CNT_W         = 4;
    localparam int OQ_DEPTH      = 2;
    localparam int LANES         = DATA_W / 16;
    localparam int OQ_W          = $clog2(OQ_DEPTH + 1);
    localparam int CMAX          = (1 << CNT_W) - 1;

    logic iol2clk = 1'b0;
    logic rst, enable, err_clr;
    logic [CNT_W-1:0] rd_cnt, wr_cnt, wr16_cnt, byp_cnt;
    logic [15:0]      last_tag;
    logic [39:0]      last_pa;
    logic             hdr_evt, beat_evt;
    logic [OQ_W-1:0]  oq_level;
    logic             err_rwm, err_hdr_in_pl, err_parity, err_oq_ovf, err_oq_unf;

    niu_sii_req_tracker_if #(.DATA_W(DATA_W)) bus ();

    niu_sii_req_tracker #(
        .DATA_W(DATA_W), .PAYLOAD_BEATS(PAYLOAD_BEATS), .CNT_W(CNT_W), .OQ_DEPTH(OQ_DEPTH)
    ) dut (
        .iol2clk(iol2clk), .rst(rst), .enable(enable), .bus(bus), .err_clr(err_clr),
        .rd_cnt(rd_cnt), .wr_cnt(wr_cnt), .wr16_cnt(wr16_cnt), .byp_cnt(byp_cnt),
        .last_tag(last_tag), .last_pa(last_pa), .hdr_evt(hdr_evt), .beat_evt(beat_evt),
        .oq_level(oq_level), .err_rwm(err_rwm), .err_hdr_in_pl(err_hdr_in_pl),
        .err_parity(err_parity), .err_oq_ovf(err_oq_ovf), .err_oq_unf(err_oq_unf)
    );

    always #5 iol2clk = ~iol2clk;

    int checks = 0;
    int errors = 0;
    int beat_pulses = 0;

    // Reference model: beats still owed by the current write (0 = no write open).
    int          m_rd, m_wr, m_wr16, m_byp, m_left, m_oq;
    logic [15:0] m_tag;
    logic [39:0] m_pa;
    bit          m_hdr_evt, m_beat_evt;
    bit          m_e_rwm, m_e_hip, m_e_par, m_e_ovf, m_e_unf;

    function automatic logic [LANES-1:0] good_par(input logic [DATA_W-1:0] d);
        logic [LANES-1:0] p;
        for (int i = 0; i < LANES; i++) p[i] = ^d[16*i +: 16];
        return p;
    endfunction

    function automatic int sat(input int v);
        return (v > CMAX) ? CMAX : v;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        bit hv, acc, det_par, det_hip, det_rwm, det_ovf, det_unf;
        int rwm, delta;
        hv  = bus.niu_sii_hdr_vld;
        rwm = {bus.niu_sii_datareq, bus.niu_sii_datareq16};
        if (rst) begin
            m_rd = 0; m_wr = 0; m_wr16 = 0; m_byp = 0; m_left = 0; m_oq = 0;
            m_tag = 16'h0000; m_pa = 40'h0;
            m_hdr_evt = 0; m_beat_evt = 0;
            m_e_rwm = 0; m_e_hip = 0; m_e_par = 0; m_e_ovf = 0; m_e_unf = 0;
        end else if (!enable) begin
            m_hdr_evt = 0; m_beat_evt = 0;
        end else begin
            acc = 0; det_hip = 0; det_rwm = 0; det_ovf = 0; det_unf = 0;
            det_par = (hv || m_left > 0) && (bus.niu_sii_parity !== good_par(bus.niu_sii_data));
            m_beat_evt = (m_left > 0);
            if (m_left > 0) begin
                det_hip = hv;
                m_left  = m_left - 1;
            end else if (hv && rwm == 3) begin
                det_rwm = 1;
            end else if (hv) begin
                acc   = 1;
                m_tag = bus.niu_sii_data[79:64];
                m_pa  = bus.niu_sii_data[39:0];
                if (rwm == 0) m_rd = sat(m_rd + 1);
                if (rwm == 2) begin m_wr = sat(m_wr + 1); m_left = PAYLOAD_BEATS; end
                if (rwm == 1) begin m_wr16 = sat(m_wr16 + 1); m_left = 1; end
                if (bus.niu_sii_reqbypass) m_byp = sat(m_byp + 1);
            end
            delta = int'(acc && !bus.niu_sii_reqbypass) - int'(bus.sii_niu_oqdq);
            if (delta > 0 && m_oq == OQ_DEPTH) det_ovf = 1;
            else if (delta < 0 && m_oq == 0) det_unf = 1;
            else m_oq = m_oq + delta;
            m_hdr_evt = acc;
            m_e_rwm = (m_e_rwm && !err_clr) || det_rwm;
            m_e_hip = (m_e_hip && !err_clr) || det_hip;
            m_e_par = (m_e_par && !err_clr) || det_par;
            m_e_ovf = (m_e_ovf && !err_clr) || det_ovf;
            m_e_unf = (m_e_unf && !err_clr) || det_unf;
        end
    endtask

    task automatic check_all();
        check("rd_cnt", rd_cnt, m_rd);
        check("wr_cnt", wr_cnt, m_wr);
        check("wr16_cnt", wr16_cnt, m_wr16);
        check("byp_cnt", byp_cnt, m_byp);
        check("last_tag", last_tag, m_tag);
        check("last_pa", last_pa, m_pa);
        check("hdr_evt", hdr_evt, m_hdr_evt);
        check("beat_evt", beat_evt, m_beat_evt);
        check("oq_level", oq_level, m_oq);
        check("err_rwm", err_rwm, m_e_rwm);
        check("err_hdr_in_pl", err_hdr_in_pl, m_e_hip);
        check("err_parity", err_parity, m_e_par);
        check("err_oq_ovf", err_oq_ovf, m_e_ovf);
        check("err_oq_unf", err_oq_unf, m_e_unf);
    endtask

    task automatic tick();
        model_edge();
        @(posedge iol2clk);
        #1;
        check_all();
        if (beat_evt === 1'b1) beat_pulses++;
        bus.niu_sii_hdr_vld = 1'b0;
        bus.sii_niu_oqdq    = 1'b0;
        err_clr             = 1'b0;
    endtask

    task automatic drive(input bit hv, input bit byp, input bit [1:0] rwm, input bit flip);
        logic [DATA_W-1:0] d;
        d = {$urandom, $urandom, $urandom, $urandom};
        bus.niu_sii_hdr_vld   = hv;
        bus.niu_sii_reqbypass = byp;
        bus.niu_sii_datareq   = rwm[1];
        bus.niu_sii_datareq16 = rwm[0];
        bus.niu_sii_parity    = good_par(d);
        if (flip) d[17] = ~d[17];
        bus.niu_sii_data = d;
    endtask

    task automatic hdr(input bit byp, input bit [1:0] rwm, input logic [15:0] tag, input logic [39:0] pa);
        logic [DATA_W-1:0] d;
        drive(1'b1, byp, rwm, 1'b0);
        d = bus.niu_sii_data;
        d[79:64] = tag;
        d[39:0]  = pa;
        bus.niu_sii_data   = d;
        bus.niu_sii_parity = good_par(d);
    endtask

    task automatic beat(input bit flip);
        drive(1'b0, 1'b0, 2'b00, flip);
    endtask

    initial begin
        rst = 1'b1; enable = 1'b1; err_clr = 1'b0;
        bus.sii_niu_oqdq = 1'b0;
        drive(1'b0, 1'b0, 2'b00, 1'b0);
        tick(); tick();
        check("reset_rd", rd_cnt, 64'd0);
        check("reset_oq", oq_level, 64'd0);
        rst = 1'b0;

        // Read header into the ordered queue
        hdr(1'b0, 2'b00, 16'h00A5, 40'h12_3456_7890); tick();
        check("read_rd", rd_cnt, 64'd1);
        check("read_tag", last_tag, 64'h00A5);
        check("read_pa", last_pa, 64'h12_3456_7890);
        check("read_oq", oq_level, 64'd1);
        beat(1'b0); tick();
        check("read_nobeat", beat_evt, 64'd0);

        // Back-to-back full writes on the bypass queue
        beat_pulses = 0;
        for (int w = 0; w < 2; w++) begin
            hdr(1'b1, 2'b10, 16'h1000 + 16'(w), 40'hAB_0000_0000 + 40'(w)); tick();
            for (int b = 0; b < PAYLOAD_BEATS; b++) begin beat(1'b0); tick(); end
        end
        beat(1'b0); tick();
        check("b2b_wr", wr_cnt, 64'd2);
        check("b2b_beats", beat_pulses, 64'd8);
        check("b2b_hip", err_hdr_in_pl, 64'd0);
        check("b2b_par", err_parity, 64'd0);

        // 16B write, gap, then a header; then a header one cycle too early
        beat_pulses = 0;
        hdr(1'b1, 2'b01, 16'h0016, 40'h1); tick();
        beat(1'b0); tick();
        beat(1'b0); tick();
        hdr(1'b1, 2'b00, 16'h0777, 40'h2); tick();
        check("w16_cnt", wr16_cnt, 64'd1);
        check("w16_beats", beat_pulses, 64'd1);
        check("w16_next_tag", last_tag, 64'h0777);
        hdr(1'b1, 2'b01, 16'h0017, 40'h3); tick();
        hdr(1'b1, 2'b00, 16'h0888, 40'h4); tick();
        check("early_hip", err_hdr_in_pl, 64'd1);
        check("early_tag", last_tag, 64'h0017);
        err_clr = 1'b1; tick();
        check("clr_hip", err_hdr_in_pl, 64'd0);

        // Parity error on beat 3
        hdr(1'b1, 2'b10, 16'h0040, 40'h5); tick();
        beat(1'b0); tick();
        beat(1'b0); tick();
        beat(1'b1); tick();
        check("par_set", err_parity, 64'd1);
        beat(1'b0); tick();
        err_clr = 1'b1; tick();
        check("par_clr", err_parity, 64'd0);

        // Ordered-queue overflow and underflow
        bus.sii_niu_oqdq = 1'b1; tick();
        for (int i = 0; i < 3; i++) begin hdr(1'b0, 2'b00, 16'(i), 40'(i)); tick(); end
        check("ovf_set", err_oq_ovf, 64'd1);
        check("ovf_level", oq_level, 64'd2);
        for (int i = 0; i < 3; i++) begin bus.sii_niu_oqdq = 1'b1; tick(); end
        check("unf_set", err_oq_unf, 64'd1);
        check("unf_level", oq_level, 64'd0);

        // Enable low mid-payload freezes the beat position
        err_clr = 1'b1; tick();
        hdr(1'b1, 2'b10, 16'h0050, 40'h6); tick();
        beat(1'b0); tick();
        enable = 1'b0;
        hdr(1'b1, 2'b00, 16'h0051, 40'h7); tick();
        hdr(1'b1, 2'b00, 16'h0052, 40'h8); tick();
        check("frz_evt", hdr_evt, 64'd0);
        enable = 1'b1;
        for (int b = 0; b < PAYLOAD_BEATS - 1; b++) begin beat(1'b0); tick(); end
        hdr(1'b1, 2'b00, 16'h0053, 40'h9); tick();
        check("frz_resume_evt", hdr_evt, 64'd1);
        check("frz_resume_hip", err_hdr_in_pl, 64'd0);

        // Reset mid-payload discards the write
        hdr(1'b1, 2'b10, 16'h0060, 40'hA); tick();
        beat(1'b0); tick();
        beat(1'b0); tick();
        rst = 1'b1; beat(1'b0); tick();
        check("rst_wr", wr_cnt, 64'd0);
        check("rst_tag", last_tag, 64'd0);
        rst = 1'b0;
        hdr(1'b0, 2'b00, 16'h0061, 40'hB); tick();
        check("rst_next_rd", rd_cnt, 64'd1);
        check("rst_next_evt", hdr_evt, 64'd1);

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            rst     = ($urandom_range(0, 99) == 0);
            enable  = ($urandom_range(0, 9) != 0);
            err_clr = ($urandom_range(0, 19) == 0);
            bus.sii_niu_oqdq = ($urandom_range(0, 2) == 0);
            drive($urandom_range(0, 9) < 4, $urandom_range(0, 1) == 1,
                  2'($urandom_range(0, 3)), $urandom_range(0, 29) == 0);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/niu_sii_req_tracker.md
NIU_SII_REQ_TRACKER -- requirements
Module: niu_sii_req_tracker

Interface
REQ-001 Parameter DATA_W, 128, NIU->SII data width; multiple of 16, at least 80.
REQ-002 Parameter PAYLOAD_BEATS, 4, payload beats of a full (64B) DMA write; range 1..16.
REQ-003 Parameter CNT_W, 32, width of every event counter.
REQ-004 Parameter OQ_DEPTH, 16, SII ordered-queue capacity in headers.
REQ-005 Port iol2clk, in, 1, sole clock; all logic is on its rising edge.
REQ-006 Port rst, in, 1, synchronous active-high reset.
REQ-007 Port enable, in, 1, tracking enable; when 0, state and outputs hold and event pulses are 0.
REQ-008 Port niu_sii_hdr_vld, in, 1, header cycle valid.
REQ-009 Port niu_sii_reqbypass, in, 1, header targets bypass queue (1) or ordered queue (0).
REQ-010 Port niu_sii_datareq / niu_sii_datareq16, in, 1 each, request type rwm = {datareq, datareq16}.
REQ-011 Port niu_sii_data, in, DATA_W, header or payload bits; niu_sii_parity, in, DATA_W/16, lane parity.
REQ-012 Port sii_niu_oqdq, in, 1, one ordered-queue entry dequeued.
REQ-013 Port err_clr, in, 1, clears all sticky error flags.
REQ-014 Ports rd_cnt, wr_cnt, wr16_cnt, byp_cnt, out, CNT_W each, accepted-header counts.
REQ-015 Ports last_tag, out, 16, and last_pa, out, 40, fields of the last accepted header.
REQ-016 Ports hdr_evt, beat_evt, out, 1 each, single-cycle pulses for accepted header and payload beat.
REQ-017 Port oq_level, out, $clog2(OQ_DEPTH+1), outstanding ordered-queue headers.
REQ-018 Ports err_rwm, err_hdr_in_pl, err_parity, err_oq_ovf, err_oq_unf, out, 1 each, sticky errors.

Function
REQ-019 rwm decode: 00 = read, no payload; 10 = full write, PAYLOAD_BEATS beats; 01 = 16B write, 1 beat; 11 = illegal.
REQ-020 FSM states: IDLE and PAYLOAD; beat counter width $clog2(PAYLOAD_BEATS+1).
REQ-021 In IDLE, hdr_vld with legal rwm is an accepted header; next cycle hdr_evt=1 and counters/last fields reflect it.
REQ-022 Accepted header: last_tag = data[79:64], last_pa = data[39:0]; rwm selects rd_cnt, wr_cnt or wr16_cnt +1; reqbypass=1 also adds byp_cnt +1.
REQ-023 Accepted write moves IDLE->PAYLOAD, loading beats-remaining; beats are the consecutive cycles immediately after the header.
REQ-024 Each PAYLOAD cycle is one beat: beat_evt=1 next cycle, remaining decrements; at 0 return to IDLE.
REQ-025 A header in the cycle after the last beat is accepted normally (back-to-back writes, no gap).
REQ-026 hdr_vld in PAYLOAD: set err_hdr_in_pl, header not counted, beat still consumed.
REQ-027 hdr_vld with rwm=11 in IDLE: set err_rwm, no count, no state change.
REQ-028 Parity: niu_sii_parity[i] must equal XOR of data[16i+15:16i]; any mismatch on a header or beat cycle sets err_parity.
REQ-029 Counters saturate at all-ones and never wrap.
REQ-030 oq_level: +1 per accepted ordered-queue header (reqbypass=0), -1 per sii_niu_oqdq; both same cycle = unchanged.
REQ-031 oq_level at OQ_DEPTH with increment and no dequeue: set err_oq_ovf, level holds.
REQ-032 oq_level at 0 with dequeue and no increment: set err_oq_unf, level stays 0.
REQ-033 err_clr clears all error flags; an error detected in the same cycle wins (flag stays 1).
REQ-034 enable=0 during PAYLOAD freezes beats-remaining; tracking resumes from the same beat when enable returns.

Reset
REQ-035 rst=1 at an edge: FSM IDLE, counters, last_tag, last_pa, oq_level, pulses and error flags 0 next cycle.
REQ-036 rst has priority over all inputs, including mid-payload; a partial write is discarded, uncounted and unflagged.

Verification
REQ-037 Read header: rwm=00, bypass=0, data[79:64]=16'h00A5, data[39:0]=40'h12_3456_7890 -> rd_cnt=1, last_tag=00A5, oq_level=1, no beats.
REQ-038 Full write, PAYLOAD_BEATS=4: header then 4 beats, second header on the next cycle -> wr_cnt=2, 8 beat_evt pulses, no errors.
REQ-039 16B write then header on the second cycle after it -> wr16_cnt=1, 1 beat_evt; header accepted; inject hdr one cycle early instead -> err_hdr_in_pl=1.
REQ-040 Flip data bit 17 on beat 3 -> err_parity=1; assert err_clr -> flag 0 next cycle.
REQ-041 OQ_DEPTH=2: 3 ordered headers -> err_oq_ovf, oq_level=2; 3 oqdq -> level 0, err_oq_unf=1.
REQ-042 rst after 2 of 4 beats -> all outputs 0, IDLE; next header accepted normally.
